xnor_gate: RTL and testbench

Bitwise XNOR / equality-compare primitive in the basic-gates library. Its primary output `y` is the purely combinational bitwise XNOR of two operand vectors, usable as a plain logic gate. Around that core, a registered stage provides a pipelined copy of the result, an all-bits-equal flag, a count of matching bits and a sticky mismatch flag. These serve compare and checker datapaths.

---
 rtl/xnor_gate_pkg.sv | 10 +
 rtl/xnor_popcount.sv | 13 +
 rtl/xnor_gate.sv | 40 ++++
 tb/tb_xnor_gate.sv | 117 +++++++++++
 4 files changed

// File: rtl/xnor_gate_pkg.sv
// xnor_gate_pkg: shared width helper and reset values for the xnor_gate registers
package xnor_gate_pkg;
  localparam logic RST_Y_BIT   = 1'b0;
  localparam logic RST_EQ      = 1'b0;
  localparam logic RST_CNT_BIT = 1'b0;
  localparam logic RST_STICKY  = 1'b0;
  function automatic int cnt_width(int w);
    return $clog2(w + 1);
  endfunction
endpackage

// File: rtl/xnor_popcount.sv
// xnor_popcount: combinational count of set bits in a WIDTH-bit vector
module xnor_popcount import xnor_gate_pkg::*; #(
  parameter int WIDTH = 1,
  parameter int CNT_W = cnt_width(WIDTH)
) (
  input  logic [WIDTH-1:0] vec_i,
  output logic [CNT_W-1:0] cnt_o
);
  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < WIDTH; i++) cnt_o = cnt_o + CNT_W'(vec_i[i]);
  end
endmodule

// File: rtl/xnor_gate.sv
// xnor_gate: bitwise XNOR gate with registered copy, equality flag, match count and sticky mismatch
module xnor_gate import xnor_gate_pkg::*; #(
  parameter int WIDTH = 1,
  parameter int CNT_W = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q,
  output logic             eq_q,
  output logic [CNT_W-1:0] match_cnt_q,
  output logic             mismatch_sticky
);
  logic [CNT_W-1:0] cnt_d;
  logic             eq_d;
  logic             sticky_d;
  logic             sticky_q;
  assign y = ~(a ^ b);
  assign eq_d = &y;
  // a mismatch outranks clr so no event is lost
  assign sticky_d = ~eq_d | (~clr & sticky_q);
  assign mismatch_sticky = sticky_q;
  xnor_popcount #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_pop (.vec_i(y), .cnt_o(cnt_d));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q         <= {WIDTH{RST_Y_BIT}};
      eq_q        <= RST_EQ;
      match_cnt_q <= {CNT_W{RST_CNT_BIT}};
      sticky_q    <= RST_STICKY;
    end else begin
      y_q         <= y;
      eq_q        <= eq_d;
      match_cnt_q <= cnt_d;
      sticky_q    <= sticky_d;
    end
  end
endmodule

// File: tb/tb_xnor_gate.sv
// tb_xnor_gate: directed vectors with a scoreboard queue checked by a posedge monitor
module tb_xnor_gate;
  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       clr;
    logic [7:0] y;
    logic       eq;
    logic [3:0] cnt;
    logic       st;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  logic [7:0] a8 = 8'h00, b8 = 8'h00;
  logic [7:0] y8, yq8;
  logic eq8, st8;
  logic [3:0] cnt8;
  logic a1 = 1'b0, b1 = 1'b0;
  logic rst1_n;
  logic y1, yq1, eq1, cnt1, st1;
  int n_vec = 0, n_err = 0;
  vec_t exp_q[$];
  vec_t m;
  vec_t tbl [9] = '{
    '{8'hA5, 8'hA5, 1'b0, 8'hFF, 1'b1, 4'd8, 1'b0},
    '{8'hF0, 8'h0F, 1'b0, 8'h00, 1'b0, 4'd0, 1'b1},
    '{8'h3C, 8'h3C, 1'b0, 8'hFF, 1'b1, 4'd8, 1'b1},
    '{8'h3C, 8'h3C, 1'b1, 8'hFF, 1'b1, 4'd8, 1'b0},
    '{8'h55, 8'h54, 1'b1, 8'hFE, 1'b0, 4'd7, 1'b1},
    '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 4'd8, 1'b0},
    '{8'h12, 8'h34, 1'b0, 8'hD9, 1'b0, 4'd5, 1'b1},
    '{8'hFF, 8'hE3, 1'b0, 8'hE3, 1'b0, 4'd5, 1'b1},
    '{8'h0F, 8'h0E, 1'b0, 8'hFE, 1'b0, 4'd7, 1'b1}
  };
  logic [3:0] tt_y = 4'b1001;
  xnor_gate #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .a(a8), .b(b8), .y(y8), .y_q(yq8),
    .eq_q(eq8), .match_cnt_q(cnt8), .mismatch_sticky(st8)
  );
  xnor_gate #(.WIDTH(1)) u1 (
    .clk(1'b0), .rst_n(rst1_n), .clr(1'b0), .a(a1), .b(b1), .y(y1), .y_q(yq1),
    .eq_q(eq1), .match_cnt_q(cnt1), .mismatch_sticky(st1)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      m = exp_q.pop_front();
      chk("y_q", 32'(yq8), 32'(m.y));
      chk("eq_q", 32'(eq8), 32'(m.eq));
      chk("match_cnt_q", 32'(cnt8), 32'(m.cnt));
      chk("mismatch_sticky", 32'(st8), 32'(m.st));
    end
  end
  initial begin
    for (int i = 0; i < 4; i++) begin
      {a1, b1} = 2'(i);
      #5;
      chk("y_w1", 32'(y1), 32'(tt_y[3-i]));
      #5;
    end
    @(negedge clk);
    #1;
    chk("rst_y_q", 32'(yq8), 32'h0);
    chk("rst_eq_q", 32'(eq8), 32'h0);
    chk("rst_cnt", 32'(cnt8), 32'h0);
    chk("rst_sticky", 32'(st8), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      a8 = tbl[i].a;
      b8 = tbl[i].b;
      clr = tbl[i].clr;
      #1;
      chk("y_comb", 32'(y8), 32'(tbl[i].y));
      exp_q.push_back(tbl[i]);
    end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_y_q", 32'(yq8), 32'h0);
    chk("midrst_eq_q", 32'(eq8), 32'h0);
    chk("midrst_cnt", 32'(cnt8), 32'h0);
    chk("midrst_sticky", 32'(st8), 32'h0);
    chk("midrst_y", 32'(y8), 32'hE3);
    a8 = 8'h00;
    b8 = 8'h00;
    #0.5;
    chk("midrst_y_track", 32'(y8), 32'hFF);
    @(negedge clk);
    rst_n = 1'b1;
    a8 = tbl[8].a;
    b8 = tbl[8].b;
    clr = tbl[8].clr;
    #1;
    chk("y_comb", 32'(y8), 32'(tbl[8].y));
    exp_q.push_back(tbl[8]);
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
